// File: rtl/mine_placer_fsm_if.sv
// rtl/mine_placer_fsm_if.sv - request/board bundle between a requester and the mine placer
interface mine_placer_fsm_if #(
  parameter int TOTAL_SQUARES = 25,
  parameter int INDEX_WIDTH   = $clog2(TOTAL_SQUARES)
);
  logic                     gen;
  logic [INDEX_WIDTH-1:0]   safe_index;
  logic [TOTAL_SQUARES-1:0] mine_map;
  logic                     busy;
  logic                     map_valid;
  logic                     adj_start;

  modport master (
    output gen, safe_index,
    input  mine_map, busy, map_valid, adj_start
  );

  modport slave (
    input  gen, safe_index,
    output mine_map, busy, map_valid, adj_start
  );
endinterface

// File: rtl/mine_placer_fsm.sv
// rtl/mine_placer_fsm.sv - places NUM_MINES mines on the board using a free-running LFSR
module mine_placer_fsm #(
  parameter int          GRID_SIZE     = 5,
  parameter int          TOTAL_SQUARES = GRID_SIZE * GRID_SIZE,
  parameter int          INDEX_WIDTH   = $clog2(TOTAL_SQUARES),
  parameter int          NUM_MINES     = 5,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  mine_placer_fsm_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(TOTAL_SQUARES + 1);
  // Count value at which the next accepted candidate is the final mine.
  localparam logic [CNT_WIDTH-1:0] LAST_MINE =
    (NUM_MINES > 0) ? CNT_WIDTH'(NUM_MINES - 1) : '0;
  // One extra bit so LFSR values beyond the board compare cleanly.
  localparam logic [INDEX_WIDTH:0]     TILE_LIMIT = (INDEX_WIDTH + 1)'(TOTAL_SQUARES);
  localparam logic [TOTAL_SQUARES-1:0] ONE_TILE   = TOTAL_SQUARES'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [TOTAL_SQUARES-1:0] mine_map_q, mine_map_d;
  logic [INDEX_WIDTH-1:0]   safe_q, safe_d;
  logic [CNT_WIDTH-1:0]     placed_q, placed_d;
  logic                     map_valid_q, map_valid_d;
  logic                     adj_start_q, adj_start_d;

  logic [INDEX_WIDTH-1:0]   cand;
  logic [TOTAL_SQUARES-1:0] cand_onehot;
  logic                     cand_ok;

  // Free-running Fibonacci LFSR (taps 16,14,13,11), advances in every state.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Candidate tile from the LFSR and whether it may receive a mine.
  always_comb begin
    cand        = lfsr_q[INDEX_WIDTH-1:0];
    cand_onehot = ONE_TILE << cand;
    cand_ok     = ({1'b0, cand} < TILE_LIMIT) && (cand != safe_q) &&
                  ((mine_map_q & cand_onehot) == '0);
  end

  // Next-state and board update; adj_start only pulses on the edge entering DONE.
  always_comb begin
    state_d     = state_q;
    mine_map_d  = mine_map_q;
    safe_d      = safe_q;
    placed_d    = placed_q;
    map_valid_d = map_valid_q;
    adj_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.gen) begin
          state_d = CLEAR;
          safe_d  = bus.safe_index;
        end
      end
      CLEAR: begin
        mine_map_d  = '0;
        placed_d    = '0;
        map_valid_d = 1'b0;
        if (NUM_MINES == 0) begin
          state_d     = DONE;
          map_valid_d = 1'b1;
          adj_start_d = 1'b1;
        end else begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        if (cand_ok) begin
          mine_map_d = mine_map_q | cand_onehot;
          placed_d   = placed_q + CNT_WIDTH'(1);
          if (placed_q == LAST_MINE) begin
            state_d     = DONE;
            map_valid_d = 1'b1;
            adj_start_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.gen) begin
          state_d = CLEAR;
          safe_d  = bus.safe_index;
        end
      end
      default: begin
        state_d     = IDLE;
        mine_map_d  = '0;
        safe_d      = '0;
        placed_d    = '0;
        map_valid_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      mine_map_q  <= '0;
      safe_q      <= '0;
      placed_q    <= '0;
      map_valid_q <= 1'b0;
      adj_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mine_map_q  <= mine_map_d;
      safe_q      <= safe_d;
      placed_q    <= placed_d;
      map_valid_q <= map_valid_d;
      adj_start_q <= adj_start_d;
    end
  end

  assign bus.busy      = (state_q == CLEAR) || (state_q == PLACE);
  assign bus.mine_map  = mine_map_q;
  assign bus.map_valid = map_valid_q;
  assign bus.adj_start = adj_start_q;

endmodule
